mem_scan_reader: RTL and testbench
==================================

MEM_SCAN_READER -- requirements
Module: mem_scan_reader

Interface
REQ-001 Parameter ADDR_W, 4, SRAM address width; the scan covers 2**ADDR_W words.
REQ-002 Parameter DATA_W, 32, SRAM word width.
REQ-003 Port Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Port Reset  input  1  asynchronous, active-high reset.
REQ-005 Port Start  input  1  request to begin a scan; sampled on the rising edge.
REQ-006 Port Key  input  DATA_W  search word, latched when Start is accepted.
REQ-007 Port ReadAddress  output  ADDR_W  registered address driven to the SRAM ReadAddress.
REQ-008 Port ReadBus  input  DATA_W  SRAM read data, valid within the same cycle (0.3 ns output delay).
REQ-009 Port Busy  output  1  scan in progress.
REQ-010 Port Done  output  1  one-cycle pulse marking that results are final.
REQ-011 Port MatchFound  output  1  at least one word equalled Key.
REQ-012 Port MatchAddr  output  ADDR_W  lowest matching address; 0 if none.
REQ-013 Port MatchCount  output  ADDR_W+1  number of matching words, 0..16.

Function
REQ-014 The FSM SHALL use the states IDLE, SCAN, FLUSH and DONE.
REQ-015 Start SHALL be accepted only in IDLE or DONE and SHALL be ignored in SCAN and FLUSH.
REQ-016 On acceptance at edge E0: latch Key, clear all results, set ReadAddress=0 and Busy=1, go to SCAN.
REQ-017 SCAN edge with ReadAddress=k: register ReadBus into DataQ, register k into AddrQ, set ValidQ=1, increment ReadAddress.
REQ-018 At k=2**ADDR_W-1, ReadAddress SHALL wrap to 0 and the FSM SHALL go to FLUSH; no address is reissued.
REQ-019 Compare stage, every edge with ValidQ=1: if DataQ==KeyQ, increment MatchCount.
REQ-020 Compare stage, first such hit only: set MatchFound=1 and MatchAddr=AddrQ.
REQ-021 FLUSH SHALL commit the last compare and go to DONE; Busy SHALL drop and Done SHALL rise at E17 (2**ADDR_W+1 edges after E0).
REQ-022 DONE SHALL last exactly one cycle and then go to IDLE, unless Start is asserted in DONE, which begins a new scan directly.
REQ-023 MatchFound, MatchAddr and MatchCount SHALL hold their values until the next accepted Start.
REQ-024 ReadAddress SHALL remain 0 in IDLE and DONE.
REQ-025 MatchCount SHALL NOT saturate below its full range; 16 matches SHALL read as 5'd16.

Reset
REQ-026 Reset SHALL asynchronously force state=IDLE and ReadAddress=0.
REQ-027 Reset SHALL asynchronously force Busy=0, Done=0, MatchFound=0, MatchAddr=0, MatchCount=0, ValidQ=0, DataQ=0, KeyQ=0.
REQ-028 Reset asserted mid-scan SHALL discard the partial results; the first Start after release SHALL perform a full, clean scan.

Configuration
REQ-029 Macro SCAN_MASK_EN: when defined, add port Mask input DATA_W, latched with Key; the match rule becomes (DataQ & MaskQ)==(KeyQ & MaskQ).
REQ-030 Without SCAN_MASK_EN, the Mask port SHALL be absent and the compare SHALL be full-word equality.

Structure
REQ-031 Package mem_scan_pkg SHALL hold the state enum, default ADDR_W/DATA_W constants and the derived MatchCount width.
REQ-032 Sub-module mem_scan_cmp SHALL contain the combinational (optionally masked) word compare; all other logic stays in mem_scan_reader.

Verification
REQ-033 All words 32'h0, Key=32'h0 -> MatchCount=16, MatchAddr=0, MatchFound=1, Done at E17.
REQ-034 Mem[i]=i, Key=32'h9 -> MatchCount=1, MatchAddr=9, MatchFound=1; ReadAddress steps 0..15 one value per cycle.
REQ-035 Key=32'hDEAD_BEEF not present -> MatchFound=0, MatchAddr=0, MatchCount=0, Done pulses once.
REQ-036 Mem[3]=Mem[12]=Key, extra Start pulse at cycle 5 -> MatchAddr=3, MatchCount=2, extra Start ignored, a single Done.
REQ-037 Reset asserted at cycle 8 of a scan -> all outputs 0 immediately; a new Start afterwards gives the correct results from REQ-034.
REQ-038 SCAN_MASK_EN defined, Mask=32'h0000_FFFF, Key=32'h1234_5678, Mem[5]=32'hFFFF_5678 -> MatchAddr=5, MatchCount=1.

Source files
------------

// File: rtl/mem_scan_pkg.sv
// Shared types and default sizing for the SRAM scan reader.
// Optional build macro SCAN_MASK_EN enables the masked compare in the reader.
package mem_scan_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_scan_cmp.sv
// Combinational word compare for the scan reader.
// With SCAN_MASK_EN defined only the bits set in mask take part in the match.
module mem_scan_cmp
  import mem_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] key,
`ifdef SCAN_MASK_EN
  input  logic [DATA_W-1:0] mask,
`endif
  output logic              hit
);

`ifdef SCAN_MASK_EN
  assign hit = ((data ^ key) & mask) == '0;
`else
  assign hit = (data == key);
`endif

endmodule

// File: rtl/mem_scan_reader.sv
// Walks every SRAM word once, counting words equal to a latched key and noting the first hit.
// Optional build macro SCAN_MASK_EN adds a Mask port latched alongside Key.
module mem_scan_reader
  import mem_scan_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] Key,
`ifdef SCAN_MASK_EN
  input  logic [DATA_W-1:0] Mask,
`endif
  output logic [ADDR_W-1:0] ReadAddress,
  input  logic [DATA_W-1:0] ReadBus,
  output logic              Busy,
  output logic              Done,
  output logic              MatchFound,
  output logic [ADDR_W-1:0] MatchAddr,
  output logic [ADDR_W:0]   MatchCount
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_e state, state_nxt;
  logic   accept;

  logic [DATA_W-1:0] key_p0;
  logic [DATA_W-1:0] data_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              vld_p1;
  logic              hit_p1;
`ifdef SCAN_MASK_EN
  logic [DATA_W-1:0] mask_p0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (ReadAddress == LAST_ADDR) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = DONE;
      DONE: begin
        accept    = Start;
        state_nxt = Start ? SCAN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy = (state == SCAN) || (state == FLUSH);
  assign Done = (state == DONE);

  // Stage p0 -> p1: capture the word returned for the current address
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      key_p0      <= '0;
`ifdef SCAN_MASK_EN
      mask_p0     <= '0;
`endif
      ReadAddress <= '0;
      data_p1     <= '0;
      addr_p1     <= '0;
      vld_p1      <= 1'b0;
    end else if (accept) begin
      key_p0      <= Key;
`ifdef SCAN_MASK_EN
      mask_p0     <= Mask;
`endif
      ReadAddress <= '0;
      vld_p1      <= 1'b0;
    end else if (state == SCAN) begin
      data_p1     <= ReadBus;
      addr_p1     <= ReadAddress;
      vld_p1      <= 1'b1;
      ReadAddress <= ReadAddress + 1'b1;
    end else begin
      vld_p1      <= 1'b0;
    end
  end

  mem_scan_cmp #(
    .DATA_W(DATA_W)
  ) u_cmp (
    .data (data_p1),
    .key  (key_p0),
`ifdef SCAN_MASK_EN
    .mask (mask_p0),
`endif
    .hit  (hit_p1)
  );

  // Stage p1 -> results: accumulate hits; the FLUSH edge commits the last word
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      MatchFound <= 1'b0;
      MatchAddr  <= '0;
      MatchCount <= '0;
    end else if (accept) begin
      MatchFound <= 1'b0;
      MatchAddr  <= '0;
      MatchCount <= '0;
    end else if (vld_p1 && hit_p1) begin
      MatchCount <= MatchCount + 1'b1;
      if (!MatchFound) begin
        MatchFound <= 1'b1;
        MatchAddr  <= addr_p1;
      end
    end
  end

endmodule

// File: tb/tb_mem_scan_reader.sv
// Self-checking bench for mem_scan_reader: table vectors, corner sequences and random scans vs a model.
module tb_mem_scan_reader;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int N  = 16;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic [DW-1:0] Key;
  logic [DW-1:0] Mask;
  logic [DW-1:0] ReadBus;
  logic [AW-1:0] ReadAddress;
  logic          Busy;
  logic          Done;
  logic          MatchFound;
  logic [AW-1:0] MatchAddr;
  logic [AW:0]   MatchCount;

  logic [DW-1:0] mem [N];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  assign ReadBus = mem[ReadAddress];

  mem_scan_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Key         (Key),
`ifdef SCAN_MASK_EN
    .Mask        (Mask),
`endif
    .ReadAddress (ReadAddress),
    .ReadBus     (ReadBus),
    .Busy        (Busy),
    .Done        (Done),
    .MatchFound  (MatchFound),
    .MatchAddr   (MatchAddr),
    .MatchCount  (MatchCount)
  );

  typedef struct {
    int            pat;
    logic [DW-1:0] key;
    logic          exp_f;
    logic [AW-1:0] exp_a;
    logic [AW:0]   exp_c;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < N; i++) begin
      case (pat)
        0:       mem[i] = 32'h0;
        2:       mem[i] = (i == 3 || i == 12) ? 32'hA5A5_0001 : DW'(i);
        default: mem[i] = DW'(i);
      endcase
    end
  endtask

  // Reference: scan the array directly, honouring the mask only when the feature is built in
  function automatic void model(input logic [DW-1:0] key, input logic [DW-1:0] msk,
                                output logic f, output logic [AW-1:0] a, output logic [AW:0] c);
    logic [DW-1:0] m;
`ifdef SCAN_MASK_EN
    m = msk;
`else
    m = '1;
    if (msk == 32'h1) m = '1;
`endif
    f = 1'b0; a = '0; c = '0;
    for (int i = 0; i < N; i++) begin
      if (((mem[i] ^ key) & m) == '0) begin
        if (!f) begin
          f = 1'b1;
          a = i[AW-1:0];
        end
        c = c + 1'b1;
      end
    end
  endfunction

  task automatic check_results(input string tag, input logic f, input logic [AW-1:0] a, input logic [AW:0] c);
    check({tag, ".found"}, 64'(MatchFound), 64'(f));
    check({tag, ".addr"},  64'(MatchAddr),  64'(a));
    check({tag, ".count"}, 64'(MatchCount), 64'(c));
  endtask

  // Called #1 after an edge with the reader in IDLE or DONE.
  task automatic run_scan(input string tag, input logic [DW-1:0] key, input logic [DW-1:0] msk,
                          input logic f, input logic [AW-1:0] a, input logic [AW:0] c);
    int cyc;
    bit seen;
    Key = key; Mask = msk; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    check({tag, ".busy_e0"}, 64'(Busy), 64'd1);
    check({tag, ".addr_e0"}, 64'(ReadAddress), 64'd0);
    check({tag, ".cleared"}, 64'(MatchCount), 64'd0);
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(posedge Clock); #1;
      cyc++;
      if (Done) seen = 1;
      else if (cyc < N) begin
        check({tag, ".raddr"}, 64'(ReadAddress), 64'(cyc));
        check({tag, ".busy"}, 64'(Busy), 64'd1);
      end
    end
    check({tag, ".done_edge"}, 64'(cyc), 64'(N + 1));
    check({tag, ".busy_done"}, 64'(Busy), 64'd0);
    check_results(tag, f, a, c);
    @(posedge Clock); #1;
    check({tag, ".done_pulse"}, 64'(Done), 64'd0);
    check({tag, ".raddr_idle"}, 64'(ReadAddress), 64'd0);
    check_results({tag, ".hold"}, f, a, c);
  endtask

  initial begin
    logic          mf;
    logic [AW-1:0] ma;
    logic [AW:0]   mc;
    int            done_cnt, first_done;

    vecs[0] = '{0, 32'h0000_0000, 1'b1, 4'd0,  5'd16};
    vecs[1] = '{1, 32'h0000_0009, 1'b1, 4'd9,  5'd1};
    vecs[2] = '{1, 32'hDEAD_BEEF, 1'b0, 4'd0,  5'd0};
    vecs[3] = '{2, 32'hA5A5_0001, 1'b1, 4'd3,  5'd2};
    vecs[4] = '{1, 32'h0000_000F, 1'b1, 4'd15, 5'd1};

    Reset = 1'b1; Start = 1'b0; Key = '0; Mask = '1;
    fill(1);
    #2;
    check("reset.busy",  64'(Busy), 64'd0);
    check("reset.done",  64'(Done), 64'd0);
    check("reset.raddr", 64'(ReadAddress), 64'd0);
    check_results("reset", 1'b0, '0, '0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      fill(vecs[v].pat);
      run_scan($sformatf("vec%0d", v), vecs[v].key, '1, vecs[v].exp_f, vecs[v].exp_a, vecs[v].exp_c);
    end

    // Extra Start while scanning must be ignored
    fill(2);
    Key = 32'hA5A5_0001; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    done_cnt = 0; first_done = 0;
    for (int e = 1; e <= 30; e++) begin
      if (e == 5) begin Start = 1'b1; Key = 32'h0; end
      @(posedge Clock); #1;
      Start = 1'b0;
      if (Done) begin
        done_cnt++;
        if (first_done == 0) first_done = e;
      end
    end
    check("extra.done_cnt", 64'(done_cnt), 64'd1);
    check("extra.done_edge", 64'(first_done), 64'(N + 1));
    check_results("extra", 1'b1, 4'd3, 5'd2);

    // Start held during DONE chains straight into the next scan
    fill(1);
    Key = 32'h9; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int e = 0; e < 40 && !Done; e++) begin
      @(posedge Clock); #1;
    end
    check("b2b.first_done", 64'(Done), 64'd1);
    run_scan("b2b", 32'h0, '1, 1'b1, 4'd0, 5'd1);

    // Reset mid-scan, after a partial hit
    Key = 32'h3; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (8) @(posedge Clock);
    #1 Reset = 1'b1;
    #1;
    check("midrst.busy",  64'(Busy), 64'd0);
    check("midrst.done",  64'(Done), 64'd0);
    check("midrst.raddr", 64'(ReadAddress), 64'd0);
    check_results("midrst", 1'b0, '0, '0);
    @(posedge Clock); #1 Reset = 1'b0;
    @(posedge Clock); #1;
    check("midrst.idle", 64'(Busy), 64'd0);
    run_scan("after_rst", 32'h9, '1, 1'b1, 4'd9, 5'd1);

`ifdef SCAN_MASK_EN
    fill(1);
    mem[5] = 32'hFFFF_5678;
    run_scan("mask", 32'h1234_5678, 32'h0000_FFFF, 1'b1, 4'd5, 5'd1);
`endif

    for (int r = 0; r < 12; r++) begin
      logic [DW-1:0] k, m;
      for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(0, 3));
      k = DW'($urandom_range(0, 3));
      m = (r % 3 == 0) ? 32'hFFFF_FFFE : '1;
      model(k, m, mf, ma, mc);
      run_scan($sformatf("rand%0d", r), k, m, mf, ma, mc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
